// File: rtl/jump_pkg.sv
// Shared types and default constants for the jump motion controller.
//   jstate_t : controller state (REST, RISE, FALL, COOL)
//   *_DEF    : default parameter values for jump_motion_ctrl
//   sat_add  : signed add clipped to an upper limit
package jump_pkg;

  typedef enum logic [1:0] {
    REST,
    RISE,
    FALL,
    COOL
  } jstate_t;

  localparam int W_DEF    = 10;
  localparam int DIV_DEF  = 2;
  localparam int V0_DEF   = 12;
  localparam int GRAV_DEF = 3;
  localparam int HOLD_DEF = 2;
  localparam int COOL_DEF = 6;
  localparam int MAXJ_DEF = 1;
  localparam int CUT_DEF  = 1;

  // Returns min(a + b, lim); used to cap the falling speed.
  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Clock-enable divider: tick is high for one clk cycle out of every DIV.
//   clk   : system clock
//   Reset : synchronous, active-high; counter restarts at 0
//   tick  : high while the counter sits at DIV-1 (the next edge is a tick)
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic Reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jump_motion_ctrl.sv
// Gravity-model jump controller producing the ball's per-tick Y step.
//   clk           : system clock
//   Reset         : synchronous, active-high reset
//   Jump          : jump button level, synchronous to clk
//   Ball_Y_Motion : signed Y step for the current tick (held between ticks)
//   step          : one-clk pulse on every motion tick
//   airborne      : state is RISE or FALL
//   busy          : state is not REST
module jump_motion_ctrl
  import jump_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int HW         = W + 8,
  parameter int DIV        = DIV_DEF,
  parameter int V0         = V0_DEF,
  parameter int GRAV       = GRAV_DEF,
  parameter int HOLD       = HOLD_DEF,
  parameter int COOL_TICKS = COOL_DEF,
  parameter int MAX_JUMPS  = MAXJ_DEF,
  parameter int CUT_EN     = CUT_DEF
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Jump,
  output logic [W-1:0] Ball_Y_Motion,
  output logic         step,
  output logic         airborne,
  output logic         busy
);

  localparam int HOLDW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int CCW   = (COOL_TICKS > 1) ? $clog2(COOL_TICKS) : 1;

  localparam logic [HOLDW-1:0]    HOLD_LAST = HOLDW'(HOLD - 1);
  localparam logic [CCW-1:0]      CC_INIT   = CCW'(COOL_TICKS - 1);
  localparam logic [1:0]          MAXJ      = 2'(MAX_JUMPS);
  localparam logic signed [W-1:0] VLAUNCH   = W'(-V0);

  jstate_t                state_q, state_d;
  logic signed [W-1:0]    vel_q, vel_d;
  logic signed [W-1:0]    mot_q, mot_d;
  logic [HOLDW-1:0]       hold_q, hold_d;
  logic [1:0]             jumps_q, jumps_d;
  logic [CCW-1:0]         cc_q, cc_d;
  logic signed [HW-1:0]   h_q, h_d;
  logic signed [HW-1:0]   land_sum;
  logic                   jp_q, jp_d;
  logic                   step_q;
  logic                   tick;
  logic                   press;
  logic                   launch;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk   (clk),
    .Reset (Reset),
    .tick  (tick)
  );

  assign press         = Jump & ~jp_q;
  assign Ball_Y_Motion = mot_q;
  assign step          = step_q;
  assign airborne      = (state_q == RISE) || (state_q == FALL);
  assign busy          = (state_q != REST);

  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    mot_d    = mot_q;
    hold_d   = hold_q;
    jumps_d  = jumps_q;
    cc_d     = cc_q;
    h_d      = h_q;
    jp_d     = jp_q;
    land_sum = h_q + HW'(vel_q);
    launch   = 1'b0;

    if (tick) begin
      jp_d  = Jump;
      mot_d = '0;
      unique case (state_q)
        REST: launch = press;
        RISE, FALL: begin
          if (press && (jumps_q < MAXJ)) begin
            launch = 1'b1;
          end else if ((CUT_EN != 0) && (state_q == RISE) && !Jump) begin
            vel_d   = '0;
            hold_d  = '0;
            state_d = FALL;
          end else begin
            if (hold_q == HOLD_LAST) begin
              vel_d  = W'(sat_add(int'(vel_q), GRAV, V0));
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
            mot_d    = vel_d;
            state_d  = vel_d[W-1] ? RISE : FALL;
            // Landing: the step that would reach or pass ground is clipped
            // to -H so the ball returns exactly to ground level.
            land_sum = h_q + HW'(vel_d);
            if (!vel_d[W-1] && !land_sum[HW-1]) begin
              mot_d = W'(-h_q);
              if (COOL_TICKS == 0) begin
                state_d = REST;
              end else begin
                state_d = COOL;
                cc_d    = CC_INIT;
              end
            end
          end
        end
        COOL: begin
          if (cc_q == '0) state_d = REST;
          else            cc_d    = cc_q - 1'b1;
        end
        default: state_d = REST;
      endcase

      if (launch) begin
        vel_d   = VLAUNCH;
        hold_d  = '0;
        mot_d   = VLAUNCH;
        state_d = RISE;
        jumps_d = (state_q == REST) ? 2'd1 : jumps_q + 2'd1;
      end

      h_d = h_q + HW'(mot_d);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= REST;
      vel_q   <= '0;
      mot_q   <= '0;
      hold_q  <= '0;
      jumps_q <= '0;
      cc_q    <= '0;
      h_q     <= '0;
      jp_q    <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vel_q   <= vel_d;
      mot_q   <= mot_d;
      hold_q  <= hold_d;
      jumps_q <= jumps_d;
      cc_q    <= cc_d;
      h_q     <= h_d;
      jp_q    <= jp_d;
      step_q  <= tick;
    end
  end

  // Height is measured as -(height above ground), so it never goes positive.
  a_height_nonpos : assert property (@(posedge clk) disable iff (Reset)
    (h_q[HW-1] || (h_q == '0)));

endmodule

// File: tb/tb_jump_motion_ctrl.sv
// Bench for jump_motion_ctrl: four instances with different parameter sets
// run side by side against a tick-level behavioural model; directed
// scenarios cover the documented jump profiles, then random Jump/Reset.
module tb_jump_motion_ctrl;

  localparam int NDUT = 4;
  // 0: defaults, 1: double jump without cut, 2: DIV=1, 3: DIV=4
  localparam int DIVS [NDUT] = '{2, 2, 1, 4};
  localparam int MJS  [NDUT] = '{1, 2, 1, 1};
  localparam int CUTS [NDUT] = '{1, 0, 1, 1};

  typedef struct packed {
    int div; int v0; int grav; int hold; int cool; int maxj; int cut;
  } prm_t;

  typedef struct packed {
    int cnt; int vel; int hold; int jumps; int h; int out; int cool;
    bit jp; bit air; bit stp;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       jmp [NDUT];
  logic       stp [NDUT];
  logic [9:0] ymo [NDUT];
  logic       air [NDUT];
  logic       bsy [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    jump_motion_ctrl #(
      .DIV       (DIVS[g]),
      .MAX_JUMPS (MJS[g]),
      .CUT_EN    (CUTS[g])
    ) u_dut (
      .clk           (clk),
      .Reset         (rst),
      .Jump          (jmp[g]),
      .Ball_Y_Motion (ymo[g]),
      .step          (stp[g]),
      .airborne      (air[g]),
      .busy          (bsy[g])
    );
  end

  prm_t p [NDUT];
  mdl_t m [NDUT];
  int   obs[$];
  int   sel;
  int   n_chk;
  int   n_pass;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Next-state of the model for one clk edge, written from the ground/air/
  // cooldown view of the rules: rising is simply "airborne with vel < 0".
  function automatic mdl_t mnext(input mdl_t s, input prm_t q, input logic r, input logic j);
    mdl_t n;
    bit   pr;
    n = s;
    if (r) begin
      n = '0;
      n.jp = 1'b1;
      return n;
    end
    n.stp = (s.cnt == q.div - 1);
    if (!n.stp) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    n.cnt = 0;
    pr    = j && !s.jp;
    n.jp  = j;
    n.out = 0;
    if (s.cool > 0) begin
      n.cool = s.cool - 1;
    end else if (pr && (!s.air || s.jumps < q.maxj)) begin
      n.air   = 1'b1;
      n.vel   = -q.v0;
      n.hold  = 0;
      n.out   = -q.v0;
      n.jumps = s.air ? s.jumps + 1 : 1;
    end else if (!s.air) begin
      n.out = 0;
    end else if (q.cut != 0 && s.vel < 0 && !j) begin
      n.vel  = 0;
      n.hold = 0;
    end else begin
      if (s.hold == q.hold - 1) begin
        n.vel  = (s.vel + q.grav > q.v0) ? q.v0 : s.vel + q.grav;
        n.hold = 0;
      end else begin
        n.hold = s.hold + 1;
      end
      n.out = n.vel;
      if (n.vel >= 0 && s.h + n.vel >= 0) begin
        n.out  = -s.h;
        n.air  = 1'b0;
        n.cool = q.cool;
      end
    end
    n.h = s.h + n.out;
    return n;
  endfunction

  // One clk cycle: advance models with the current inputs, then compare at
  // the following falling edge.
  task automatic cyc();
    for (int k = 0; k < NDUT; k++) m[k] = mnext(m[k], p[k], rst, jmp[k]);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk_eq($sformatf("d%0d_step", k), int'(stp[k]), int'(m[k].stp));
      chk_eq($sformatf("d%0d_y", k), int'($signed(ymo[k])), m[k].out);
      chk_eq($sformatf("d%0d_air", k), int'(air[k]), int'(m[k].air));
      chk_eq($sformatf("d%0d_busy", k), int'(bsy[k]), int'(m[k].air || m[k].cool > 0));
    end
    if (stp[sel]) obs.push_back(int'($signed(ymo[sel])));
  endtask

  task automatic ticks(input int k, input int n);
    repeat (n * p[k].div) cyc();
  endtask

  // Advance until the next rising edge of clk is a tick for instance k.
  task automatic align(input int k);
    while (m[k].cnt != p[k].div - 1) cyc();
  endtask

  function automatic int at(input int i);
    return (i < obs.size()) ? obs[i] : 99999;
  endfunction

  function automatic int nz(input int start);
    int c = 0;
    for (int i = start; i < obs.size(); i++) if (obs[i] != 0) c++;
    return c;
  endfunction

  function automatic int qsum();
    int s = 0;
    foreach (obs[i]) s += obs[i];
    return s;
  endfunction

  function automatic int qmax();
    int v = -99999;
    foreach (obs[i]) if (obs[i] > v) v = obs[i];
    return v;
  endfunction

  task automatic chk_prefix(input string tag, input int e[$]);
    if (obs.size() < e.size()) chk_eq({tag, "_len"}, obs.size(), e.size());
    else for (int i = 0; i < e.size(); i++) chk_eq($sformatf("%s_%0d", tag, i), obs[i], e[i]);
  endtask

  initial begin
    int prof[$];
    int e[$];
    n_chk  = 0;
    n_pass = 0;
    sel    = 0;
    rst    = 1'b1;
    prof   = '{-12, -12, -9, -9, -6, -6, -3, -3, 0, 0, 3, 3, 6, 6, 9, 9, 12, 12};
    for (int k = 0; k < NDUT; k++) begin
      p[k]   = '{DIVS[k], 12, 3, 2, 6, MJS[k], CUTS[k]};
      m[k]   = '0;
      m[k].jp = 1'b1;
      jmp[k] = 1'b0;
    end

    // Jump held through reset must not launch.
    jmp[0] = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    obs.delete();
    ticks(0, 5);
    chk_eq("held_rst_nz", nz(0), 0);
    chk_eq("held_rst_busy", int'(bsy[0]), 0);

    // Full default profile with Jump held through landing and cooldown.
    jmp[0] = 1'b0;
    ticks(0, 2);
    align(0);
    obs.delete();
    jmp[0] = 1'b1;
    ticks(0, 40);
    chk_prefix("prof_d0", prof);
    chk_eq("held_no_retrig", nz(18), 0);
    chk_eq("prof_sum", qsum(), 0);
    chk_eq("prof_len", obs.size(), 40);
    jmp[0] = 1'b0;
    ticks(0, 1);
    obs.delete();
    jmp[0] = 1'b1;
    ticks(0, 1);
    chk_eq("relaunch", at(0), -12);
    ticks(0, 30);
    jmp[0] = 1'b0;
    ticks(0, 2);

    // Early release while rising cuts velocity to zero.
    align(0);
    obs.delete();
    jmp[0] = 1'b1;
    ticks(0, 3);
    jmp[0] = 1'b0;
    ticks(0, 30);
    e = '{-12, -12, -9, 0, 0, 3, 3, 6, 6, 9, 6, 0};
    chk_prefix("cut", e);
    chk_eq("cut_sum", qsum(), 0);

    // Double jump at apex; a third press is ignored.
    sel = 1;
    align(1);
    obs.delete();
    jmp[1] = 1'b1;
    ticks(1, 3);
    jmp[1] = 1'b0;
    ticks(1, 5);
    jmp[1] = 1'b1;
    ticks(1, 1);
    jmp[1] = 1'b0;
    ticks(1, 2);
    jmp[1] = 1'b1;
    ticks(1, 1);
    jmp[1] = 1'b0;
    ticks(1, 40);
    chk_eq("dj_apex", at(8), -12);
    chk_eq("dj_third", at(11), -9);
    chk_eq("dj_sum", qsum(), 0);
    chk_eq("dj_max", qmax(), 12);

    // Reset in the middle of a jump.
    sel = 0;
    align(0);
    obs.delete();
    jmp[0] = 1'b1;
    ticks(0, 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_eq("rst_y", int'($signed(ymo[0])), 0);
    chk_eq("rst_air", int'(air[0]), 0);
    chk_eq("rst_busy", int'(bsy[0]), 0);
    chk_eq("rst_step", int'(stp[0]), 0);
    obs.delete();
    ticks(0, 4);
    chk_eq("rst_held_nz", nz(0), 0);
    jmp[0] = 1'b0;
    ticks(0, 1);
    align(0);
    obs.delete();
    jmp[0] = 1'b1;
    ticks(0, 1);
    chk_eq("rst_relaunch", at(0), -12);
    ticks(0, 30);
    jmp[0] = 1'b0;
    ticks(0, 2);

    // Same profile at DIV=1 and DIV=4.
    for (int k = 2; k < NDUT; k++) begin
      sel = k;
      obs.delete();
      align(k);
      jmp[k] = 1'b1;
      ticks(k, 30);
      chk_eq($sformatf("d%0d_nsteps", k), obs.size(), 30);
      chk_prefix($sformatf("prof_d%0d", k), prof);
      jmp[k] = 1'b0;
      ticks(k, 2);
    end

    // Random Jump activity with occasional reset.
    sel = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < NDUT; k++)
        if ($urandom_range(0, 4 * p[k].div - 1) == 0) jmp[k] = ~jmp[k];
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
